// File: rtl/hazard_unit_mc_pkg.sv
// Shared types for the multi-cycle pipeline hazard controller.
package hazard_unit_mc_pkg;

  typedef enum logic [1:0] {
    FORWARD_NONE = 2'b00,
    FORWARD_WB   = 2'b01,
    FORWARD_MEM  = 2'b10
  } forward_t;

  typedef enum logic [1:0] {
    IDLE,
    LU_STALL,
    MDU_BUSY
  } hz_state_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// EX-stage operand forward selector: the younger MEM result beats the older WB one.
module hazard_fwd_sel
  import hazard_unit_mc_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  output forward_t          sel
);

  always_comb begin
    // NOTE: combinational blocks assign a default first so no path can infer a latch.
    sel = FORWARD_NONE;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs))
      sel = FORWARD_MEM;
    else if (reg_write_w && (rd_w != '0) && (rd_w == rs))
      sel = FORWARD_WB;
  end

endmodule

// File: rtl/hazard_unit_mc.sv
// Pipeline hazard controller: forwarding, branch flush, multi-cycle load-use stall,
// MDU start/done handshake with busy watchdog, and data-memory freeze.
module hazard_unit_mc
  import hazard_unit_mc_pkg::*;
#(
  parameter int REG_AW          = 5,
  parameter int LOAD_USE_CYCLES = 1,
  parameter int MDU_TIMEOUT     = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rd_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  input  logic [1:0]        result_src_e,
  input  logic              mdu_op_e,
  input  logic              mdu_done,
  input  logic              pc_src_e,
  input  logic              mem_access_m,
  input  logic              dmem_ready,
  output forward_t          forward_a_e,
  output forward_t          forward_b_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_m,
  output logic              flush_w,
  output logic              mdu_start,
  output logic              mdu_timeout
);

  localparam int CNT_W = 3;
  localparam int WD_W  = $clog2(MDU_TIMEOUT + 1);

  hz_state_t        state, state_nxt;
  logic [CNT_W-1:0] lu_cnt, lu_cnt_nxt;
  logic [WD_W-1:0]  wd_cnt, wd_cnt_nxt;
  forward_t         fwd_a, fwd_b;
  logic             freeze, lu_hit;

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .rs(rs1_e), .rd_m(rd_m), .rd_w(rd_w),
    .reg_write_m(reg_write_m), .reg_write_w(reg_write_w), .sel(fwd_a)
  );

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .rs(rs2_e), .rd_m(rd_m), .rd_w(rd_w),
    .reg_write_m(reg_write_m), .reg_write_w(reg_write_w), .sel(fwd_b)
  );

  assign freeze = mem_access_m & ~dmem_ready;
  assign lu_hit = result_src_e[0] & (rd_e != '0) & ((rs1_d == rd_e) | (rs2_d == rd_e));

  always_comb begin
    forward_a_e = reset ? FORWARD_NONE : fwd_a;
    forward_b_e = reset ? FORWARD_NONE : fwd_b;
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous to clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      lu_cnt      <= '0;
      wd_cnt      <= '0;
      mdu_timeout <= 1'b0;
    end else begin
      state  <= state_nxt;
      lu_cnt <= lu_cnt_nxt;
      wd_cnt <= wd_cnt_nxt;
      if (wd_cnt_nxt == WD_W'(MDU_TIMEOUT))
        mdu_timeout <= 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    lu_cnt_nxt = lu_cnt;
    wd_cnt_nxt = wd_cnt;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    stall_e    = 1'b0;
    stall_m    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    flush_m    = 1'b0;
    flush_w    = 1'b0;
    mdu_start  = 1'b0;

    // The watchdog keeps counting busy cycles even while memory freezes the pipe.
    if ((state == MDU_BUSY) && (wd_cnt != WD_W'(MDU_TIMEOUT)))
      wd_cnt_nxt = wd_cnt + WD_W'(1);

    if (reset) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_m = 1'b1;
      flush_w = 1'b1;
    end else if (freeze) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (mdu_op_e) begin
            mdu_start  = 1'b1;
            state_nxt  = MDU_BUSY;
            wd_cnt_nxt = '0;
          end else if (pc_src_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
          end else if (lu_hit) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
            if (LOAD_USE_CYCLES > 1) begin
              state_nxt  = LU_STALL;
              lu_cnt_nxt = CNT_W'(LOAD_USE_CYCLES - 1);
            end
          end
        end
        LU_STALL: begin
          if (pc_src_e) begin
            flush_d    = 1'b1;
            flush_e    = 1'b1;
            state_nxt  = IDLE;
            lu_cnt_nxt = '0;
          end else begin
            stall_f    = 1'b1;
            stall_d    = 1'b1;
            flush_e    = 1'b1;
            lu_cnt_nxt = lu_cnt - CNT_W'(1);
            if (lu_cnt == CNT_W'(1))
              state_nxt = IDLE;
          end
        end
        MDU_BUSY: begin
          // A done pulse releases the stalls this cycle so EX advances at the next edge.
          if (mdu_done) begin
            state_nxt = IDLE;
          end else begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc: one task per feature, hand-computed expectations.
module tb_hazard_unit_mc;
  import hazard_unit_mc_pkg::*;

  logic       clk;
  logic       reset;
  logic [4:0] rs1_e, rs2_e, rs1_d, rs2_d, rd_e, rd_m, rd_w;
  logic       reg_write_m, reg_write_w;
  logic [1:0] result_src_e;
  logic       mdu_op_e, mdu_done, pc_src_e, mem_access_m, dmem_ready;

  forward_t   forward_a_e, forward_b_e;
  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e, flush_m, flush_w;
  logic       mdu_start, mdu_timeout;

  forward_t   fa_1, fb_1;
  logic       sf_1, sd_1, se_1, sm_1, fd_1, fe_1, fm_1, fw_1, start_1, to_1;

  int n_cmp = 0;
  int n_bad = 0;

  // Control vector order: {stall_f,stall_d,stall_e,stall_m,flush_d,flush_e,flush_m,flush_w,mdu_start}
  localparam logic [8:0] C_NONE  = 9'b0000_0000_0;
  localparam logic [8:0] C_RST   = 9'b0000_1111_0;
  localparam logic [8:0] C_LU    = 9'b1100_0100_0;
  localparam logic [8:0] C_START = 9'b0000_0000_1;
  localparam logic [8:0] C_BUSY  = 9'b1110_0010_0;
  localparam logic [8:0] C_FRZ   = 9'b1111_0001_0;
  localparam logic [8:0] C_BR    = 9'b0000_1100_0;

  // Stimulus vector order: {reset, mdu_op_e, mdu_done, pc_src_e, mem_access_m, dmem_not_ready}
  localparam logic [5:0] S_IDLE = 6'b000000;
  localparam logic [5:0] S_RST  = 6'b100000;
  localparam logic [5:0] S_OP   = 6'b010000;
  localparam logic [5:0] S_DONE = 6'b001000;
  localparam logic [5:0] S_PC   = 6'b000100;
  localparam logic [5:0] S_FRZ  = 6'b000011;

  hazard_unit_mc #(.REG_AW(5), .LOAD_USE_CYCLES(3), .MDU_TIMEOUT(4)) u_dut (
    .clk(clk), .reset(reset),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
    .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .result_src_e(result_src_e), .mdu_op_e(mdu_op_e), .mdu_done(mdu_done),
    .pc_src_e(pc_src_e), .mem_access_m(mem_access_m), .dmem_ready(dmem_ready),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
    .mdu_start(mdu_start), .mdu_timeout(mdu_timeout)
  );

  // Single-bubble configuration sharing the same inputs.
  hazard_unit_mc #(.REG_AW(5), .LOAD_USE_CYCLES(1), .MDU_TIMEOUT(64)) u_dut1 (
    .clk(clk), .reset(reset),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
    .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .result_src_e(result_src_e), .mdu_op_e(mdu_op_e), .mdu_done(mdu_done),
    .pc_src_e(pc_src_e), .mem_access_m(mem_access_m), .dmem_ready(dmem_ready),
    .forward_a_e(fa_1), .forward_b_e(fb_1),
    .stall_f(sf_1), .stall_d(sd_1), .stall_e(se_1), .stall_m(sm_1),
    .flush_d(fd_1), .flush_e(fe_1), .flush_m(fm_1), .flush_w(fw_1),
    .mdu_start(start_1), .mdu_timeout(to_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  function automatic logic [8:0] ctl();
    return {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w, mdu_start};
  endfunction

  function automatic logic [8:0] ctl1();
    return {sf_1, sd_1, se_1, sm_1, fd_1, fe_1, fm_1, fw_1, start_1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] s);
    reset        = s[5];
    mdu_op_e     = s[4];
    mdu_done     = s[3];
    pc_src_e     = s[2];
    mem_access_m = s[1];
    dmem_ready   = ~s[0];
  endtask

  task automatic test_reset();
    rs1_e = 5'd5; rd_m = 5'd5; reg_write_m = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(i < 2 ? S_RST : S_IDLE);
      #1;
      n_cmp++;
      if ({ctl(), ctl1(), forward_a_e, mdu_timeout} !==
          {(i < 2 ? C_RST : C_NONE), (i < 2 ? C_RST : C_NONE),
           (i < 2 ? FORWARD_NONE : FORWARD_MEM), 1'b0}) begin
        n_bad++;
        $display("FAIL reset[%0d]: ctl=%b ctl1=%b fwd_a=%b to=%b", i, ctl(), ctl1(), forward_a_e, mdu_timeout);
      end
      tick();
    end
  endtask

  task automatic test_forward();
    logic [4:0] v_rs1 [8] = '{5'd5, 5'd0, 5'd0, 5'd5, 5'd3, 5'd4, 5'd31, 5'd7};
    logic [4:0] v_rs2 [8] = '{5'd9, 5'd9, 5'd0, 5'd3, 5'd4, 5'd4, 5'd31, 5'd31};
    logic [4:0] v_rdm [8] = '{5'd5, 5'd5, 5'd0, 5'd5, 5'd4, 5'd4, 5'd31, 5'd31};
    logic [4:0] v_rdw [8] = '{5'd5, 5'd5, 5'd0, 5'd5, 5'd3, 5'd4, 5'd7, 5'd7};
    logic [1:0] v_rw  [8] = '{2'b11, 2'b11, 2'b11, 2'b01, 2'b11, 2'b00, 2'b11, 2'b10};
    forward_t   e_a   [8] = '{FORWARD_MEM, FORWARD_NONE, FORWARD_NONE, FORWARD_WB,
                              FORWARD_WB, FORWARD_NONE, FORWARD_MEM, FORWARD_NONE};
    forward_t   e_b   [8] = '{FORWARD_NONE, FORWARD_NONE, FORWARD_NONE, FORWARD_NONE,
                              FORWARD_MEM, FORWARD_NONE, FORWARD_MEM, FORWARD_MEM};
    for (int i = 0; i < 8; i++) begin
      rs1_e = v_rs1[i]; rs2_e = v_rs2[i]; rd_m = v_rdm[i]; rd_w = v_rdw[i];
      {reg_write_m, reg_write_w} = v_rw[i];
      #1;
      n_cmp++;
      if ({forward_a_e, forward_b_e} !== {e_a[i], e_b[i]}) begin
        n_bad++;
        $display("FAIL forward[%0d]: a/b got %b/%b want %b/%b", i, forward_a_e, forward_b_e, e_a[i], e_b[i]);
      end
      tick();
    end
    reg_write_m = 1'b0; reg_write_w = 1'b0;
  endtask

  task automatic test_load_use();
    // Per cycle: {load, rd_e nonzero, pc_src_e, freeze}
    logic [3:0] v  [13] = '{4'b1100, 4'b0100, 4'b0100, 4'b0100, 4'b1110, 4'b0100,
                            4'b1000, 4'b0100, 4'b1100, 4'b0001, 4'b0100, 4'b0100, 4'b0100};
    logic [8:0] e3 [13] = '{C_LU, C_LU, C_LU, C_NONE, C_BR, C_NONE,
                            C_NONE, C_NONE, C_LU, C_FRZ, C_LU, C_LU, C_NONE};
    logic [8:0] e1 [13] = '{C_LU, C_NONE, C_NONE, C_NONE, C_BR, C_NONE,
                            C_NONE, C_NONE, C_LU, C_FRZ, C_NONE, C_NONE, C_NONE};
    rs1_d = 5'd0; rs2_d = 5'd7;
    for (int i = 0; i < 13; i++) begin
      result_src_e = {1'b0, v[i][3]};
      rd_e         = v[i][2] ? 5'd7 : 5'd0;
      drive((v[i][1] ? S_PC : S_IDLE) | (v[i][0] ? S_FRZ : S_IDLE));
      #1;
      n_cmp++;
      if ({ctl(), ctl1()} !== {e3[i], e1[i]}) begin
        n_bad++;
        $display("FAIL load_use[%0d]: ctl3 got %b want %b, ctl1 got %b want %b", i, ctl(), e3[i], ctl1(), e1[i]);
      end
      tick();
    end
    result_src_e = 2'b00; rd_e = 5'd0; rs2_d = 5'd0;
    drive(S_IDLE);
  endtask

  task automatic test_mdu_handshake();
    logic [5:0] s [10] = '{S_OP, S_OP, S_OP, S_OP, S_OP, S_OP, S_DONE, S_IDLE, S_DONE, S_IDLE};
    logic [8:0] e [10] = '{C_START, C_BUSY, C_BUSY, C_BUSY, C_BUSY, C_BUSY,
                           C_NONE, C_NONE, C_NONE, C_NONE};
    for (int i = 0; i < 10; i++) begin
      drive(s[i]);
      #1;
      n_cmp++;
      if (ctl() !== e[i]) begin
        n_bad++;
        $display("FAIL mdu_handshake[%0d]: ctl got %b want %b", i, ctl(), e[i]);
      end
      tick();
    end
  endtask

  task automatic test_mdu_timeout();
    // The handshake above ran 6 busy cycles, so the flag is already set entering this test.
    logic [5:0] s [12] = '{S_RST, S_OP, S_IDLE, S_IDLE, S_FRZ, S_FRZ,
                           S_IDLE, S_IDLE, S_DONE, S_IDLE, S_RST, S_IDLE};
    logic [9:0] e [12] = '{{1'b1, C_RST}, {1'b0, C_START}, {1'b0, C_BUSY}, {1'b0, C_BUSY},
                           {1'b0, C_FRZ}, {1'b0, C_FRZ}, {1'b1, C_BUSY}, {1'b1, C_BUSY},
                           {1'b1, C_NONE}, {1'b1, C_NONE}, {1'b1, C_RST}, {1'b0, C_NONE}};
    for (int i = 0; i < 12; i++) begin
      drive(s[i]);
      #1;
      n_cmp++;
      if ({mdu_timeout, ctl()} !== e[i]) begin
        n_bad++;
        $display("FAIL mdu_timeout[%0d]: {to,ctl} got %b want %b", i, {mdu_timeout, ctl()}, e[i]);
      end
      tick();
    end
  endtask

  task automatic test_branch_freeze();
    logic [5:0] s [9] = '{S_PC | S_FRZ, S_PC | S_FRZ, S_PC, S_IDLE, S_OP | S_FRZ,
                          S_OP, S_IDLE, S_DONE, S_IDLE};
    logic [8:0] e [9] = '{C_FRZ, C_FRZ, C_BR, C_NONE, C_FRZ, C_START, C_BUSY, C_NONE, C_NONE};
    for (int i = 0; i < 9; i++) begin
      drive(s[i]);
      #1;
      n_cmp++;
      if (ctl() !== e[i]) begin
        n_bad++;
        $display("FAIL branch_freeze[%0d]: ctl got %b want %b", i, ctl(), e[i]);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_mdu();
    logic [5:0] s [12] = '{S_OP, S_OP, S_OP, S_RST, S_IDLE, S_IDLE, S_DONE, S_IDLE,
                           S_OP, S_IDLE, S_DONE, S_IDLE};
    logic [8:0] e [12] = '{C_START, C_BUSY, C_BUSY, C_RST, C_NONE, C_NONE, C_NONE, C_NONE,
                           C_START, C_BUSY, C_NONE, C_NONE};
    for (int i = 0; i < 12; i++) begin
      drive(s[i]);
      #1;
      n_cmp++;
      if (ctl() !== e[i]) begin
        n_bad++;
        $display("FAIL reset_mid_mdu[%0d]: ctl got %b want %b", i, ctl(), e[i]);
      end
      tick();
    end
  endtask

  initial begin
    rs1_e = '0; rs2_e = '0; rs1_d = '0; rs2_d = '0;
    rd_e = '0; rd_m = '0; rd_w = '0;
    reg_write_m = 1'b0; reg_write_w = 1'b0; result_src_e = 2'b00;
    drive(S_RST);
    @(posedge clk);
    #1;
    test_reset();
    test_forward();
    test_load_use();
    test_mdu_handshake();
    test_mdu_timeout();
    test_branch_freeze();
    test_reset_mid_mdu();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
